// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor pipeline.
package sprite_pkg;

    localparam int unsigned HVE_HSYNC      = 2;
    localparam int unsigned HVE_VSYNC      = 1;
    localparam int unsigned HVE_DE         = 0;
    localparam int unsigned HVE_W          = 3;
    localparam int unsigned RGB_W          = 24;
    localparam int unsigned IDX_W          = 2;
    localparam int unsigned BMP_AW         = 8;
    localparam int unsigned SPRITE_LATENCY = 3;

    typedef logic [RGB_W-1:0] rgb_t;
    typedef logic [IDX_W-1:0] color_idx_t;
    typedef logic [HVE_W-1:0] hve_t;

    // One pixel's worth of pipeline payload travelling alongside the bitmap read.
    typedef struct packed {
        hve_t hve;
        logic hit;
        rgb_t rgb;
    } pix_stage_t;

    // Index 0 is transparent and never reaches the palette output.
    function automatic rgb_t pal_lookup(input color_idx_t idx, input rgb_t p1,
                                        input rgb_t p2, input rgb_t p3);
        rgb_t c;
        c = '0;
        case (idx)
            2'd1:    c = p1;
            2'd2:    c = p2;
            2'd3:    c = p3;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sprite_bitmap_ram.sv
// 2^AW x 2-bit simple dual-port bitmap store; synchronous read returns old data on collision.
module sprite_bitmap_ram
    import sprite_pkg::*;
#(
    parameter int unsigned AW = 8
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  color_idx_t    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output color_idx_t    rdata_o
);

    localparam int unsigned DEPTH = 1 << AW;

    color_idx_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/sprite_compositor.sv
// Overlays a magnified 2bpp sprite onto the background RGB stream with a fixed
// three-cycle latency; the sprite position is latched once per frame at vsync.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int unsigned SPRITE_W   = 16,
    parameter int unsigned SPRITE_H   = 16,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned COORD_W    = 13,
    parameter rgb_t        PAL1       = 24'hFF0000,
    parameter rgb_t        PAL2       = 24'h00FF00,
    parameter rgb_t        PAL3       = 24'hFFFFFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [2:0]         hve_in,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [23:0]        bg_rgb,
    input  logic [9:0]         sprite_x,
    input  logic [9:0]         sprite_y,
    input  logic               wr_en,
    input  logic [7:0]         wr_addr,
    input  logic [1:0]         wr_data,
    output logic [2:0]         hve_out,
    output logic [23:0]        rgb,
    output logic               sprite_hit
);

    localparam int unsigned DW     = COORD_W + 1;
    localparam int unsigned COL_W  = $clog2(SPRITE_W);
    localparam int unsigned ROW_W  = $clog2(SPRITE_H);
    localparam int unsigned SPAN_X = SPRITE_W << SCALE_LOG2;
    localparam int unsigned SPAN_Y = SPRITE_H << SCALE_LOG2;

    logic [9:0]        lat_x_q, lat_x_d;
    logic [9:0]        lat_y_q, lat_y_d;
    logic              vs_q;
    logic [DW-1:0]     dx_c, dy_c;
    logic              hit_c;
    logic [BMP_AW-1:0] raddr_c;
    pix_stage_t        s1_q, s2_q;
    color_idx_t        idx1, idx2_q;
    rgb_t              rgb_d;
    logic              hit_d;

    // Position latch: only a 0->1 vsync transition loads a new position.
    always_comb begin
        lat_x_d = lat_x_q;
        lat_y_d = lat_y_q;
        if (hve_in[HVE_VSYNC] && !vs_q) begin
            lat_x_d = sprite_x;
            lat_y_d = sprite_y;
        end
    end

    // Sampling vsync during reset swallows an edge that coincides with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            lat_x_q <= '0;
            lat_y_q <= '0;
            vs_q    <= hve_in[HVE_VSYNC];
        end else begin
            lat_x_q <= lat_x_d;
            lat_y_q <= lat_y_d;
            vs_q    <= hve_in[HVE_VSYNC];
        end
    end

    // Stage 1: one extra bit keeps the offset signed so nothing wraps around.
    always_comb begin
        dx_c    = DW'(x) - DW'(lat_x_q);
        dy_c    = DW'(y) - DW'(lat_y_q);
        hit_c   = hve_in[HVE_DE] && !dx_c[DW-1] && !dy_c[DW-1] &&
                  (dx_c < DW'(SPAN_X)) && (dy_c < DW'(SPAN_Y));
        raddr_c = BMP_AW'({dy_c[SCALE_LOG2 +: ROW_W], dx_c[SCALE_LOG2 +: COL_W]});
    end

    sprite_bitmap_ram #(
        .AW(BMP_AW)
    ) u_bitmap (
        .clk_i   (clock),
        .we_i    (wr_en),
        .waddr_i (wr_addr),
        .wdata_i (wr_data),
        .raddr_i (raddr_c),
        .rdata_o (idx1)
    );

    // Stage 3 compositing; blanking overrides everything.
    always_comb begin
        rgb_d = s2_q.rgb;
        hit_d = 1'b0;
        if (s2_q.hit && (idx2_q != '0)) begin
            rgb_d = pal_lookup(idx2_q, PAL1, PAL2, PAL3);
            hit_d = 1'b1;
        end
        if (!s2_q.hve[HVE_DE]) begin
            rgb_d = '0;
            hit_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q       <= '0;
            s2_q       <= '0;
            idx2_q     <= '0;
            hve_out    <= '0;
            rgb        <= '0;
            sprite_hit <= 1'b0;
        end else begin
            s1_q       <= '{hve: hve_in, hit: hit_c, rgb: bg_rgb};
            s2_q       <= s1_q;
            idx2_q     <= idx1;
            hve_out    <= s2_q.hve;
            rgb        <= rgb_d;
            sprite_hit <= hit_d;
        end
    end

endmodule
